// File: rtl/des_round_sequencer.sv
// Control FSM for the iterative DES round datapath: accepts one block, walks the
// datapath through load, 16 key-scheduled rounds and the final permutation, then holds the result.
module des_round_sequencer #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             abort,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_data,
  input  logic [63:0]      cmd_key,
  input  logic             cmd_decrypt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic             dp_load,
  output logic [63:0]      dp_data,
  output logic [63:0]      dp_key,
  output logic             dp_round_en,
  output logic [3:0]       dp_round_idx,
  output logic [1:0]       dp_key_shift,
  output logic             dp_key_dir,
  output logic             dp_final,
  input  logic [63:0]      dp_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [63:0]      res_data_q, res_data_d;
  logic [63:0]      dp_data_q, dp_data_d;
  logic [63:0]      dp_key_q, dp_key_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       shift;
  logic             cmd_fire;
  logic             res_fire;

  assign cmd_fire = cmd_valid && cmd_ready_q && !abort;
  assign res_fire = (state_q == S_HOLD) && res_ready && !abort;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d    = state_q;
    round_d    = '0;
    res_data_d = res_data_q;
    dp_data_d  = dp_data_q;
    dp_key_d   = dp_key_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d   = S_LOAD;
          dp_data_d = cmd_data;
          dp_key_d  = cmd_key;
          dir_d     = cmd_decrypt;
        end
      end
      S_LOAD:  state_d = S_ROUND;
      S_ROUND: begin
        if (round_q == LAST_ROUND) state_d = S_FINAL;
        else                       round_d = round_q + 4'd1;
      end
      S_FINAL: begin
        state_d    = S_HOLD;
        res_data_d = dp_out;
      end
      S_HOLD: begin
        if (res_fire) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Soft clear drops the block in flight but keeps the captured block, key and result.
    if (abort) begin
      state_d    = S_IDLE;
      round_d    = '0;
      res_data_d = res_data_q;
      cnt_d      = cnt_q;
    end
    cmd_ready_d = (state_d == S_IDLE);
  end

  // Decrypt walks the schedule backwards: round 0 reuses C0/D0, which equals C16/D16.
  always_comb begin
    shift = 2'd0;
    if (state_q == S_ROUND) begin
      case (round_q)
        4'd0:              shift = dir_q ? 2'd0 : 2'd1;
        4'd1, 4'd8, 4'd15: shift = 2'd1;
        default:           shift = 2'd2;
      endcase
    end
  end

  // NOTE: ARESETN is sampled only inside the clocked block, making the reset synchronous.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      cmd_ready_q <= 1'b0;
      res_data_q  <= '0;
      dp_data_q   <= '0;
      dp_key_q    <= '0;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      state_q     <= state_d;
      round_q     <= round_d;
      cmd_ready_q <= cmd_ready_d;
      res_data_q  <= res_data_d;
      dp_data_q   <= dp_data_d;
      dp_key_q    <= dp_key_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign res_valid    = (state_q == S_HOLD);
  assign res_data     = res_data_q;
  assign busy         = (state_q != S_IDLE);
  assign blk_count    = cnt_q;
  assign dp_load      = (state_q == S_LOAD);
  assign dp_data      = dp_data_q;
  assign dp_key       = dp_key_q;
  assign dp_round_en  = (state_q == S_ROUND);
  assign dp_round_idx = round_q;
  assign dp_key_shift = shift;
  assign dp_key_dir   = dir_q;
  assign dp_final     = (state_q == S_FINAL);

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: behavioural DES round datapath, reference DES
// function feeding a result scoreboard, and directed protocol/timing steps.
module tb_des_round_sequencer;

  localparam int CNT_W = 4;

  logic             ACLK = 1'b0;
  logic             ARESETN, abort, cmd_valid, cmd_decrypt, res_ready;
  logic [63:0]      cmd_data, cmd_key, dp_out;
  logic             cmd_ready, res_valid, busy, dp_load, dp_round_en, dp_key_dir, dp_final;
  logic [63:0]      res_data, dp_data, dp_key;
  logic [CNT_W-1:0] blk_count;
  logic [3:0]       dp_round_idx;
  logic [1:0]       dp_key_shift;

  des_round_sequencer #(.ROUNDS(16), .CNT_W(CNT_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_key(cmd_key), .cmd_decrypt(cmd_decrypt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .blk_count(blk_count),
    .dp_load(dp_load), .dp_data(dp_data), .dp_key(dp_key),
    .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx),
    .dp_key_shift(dp_key_shift), .dp_key_dir(dp_key_dir),
    .dp_final(dp_final), .dp_out(dp_out)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // DES tables, bit 1 = MSB as in the standard.
  int ip_t[$]    = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                     64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int ipinv_t[$] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                     37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int e_t[$]     = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                     16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t[$]     = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int pc1_t[$]   = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t[$]   = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int sbox[8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] permute(input logic [63:0] din, input int in_w, input int tbl[$]);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < tbl.size(); i++) r[tbl.size() - 1 - i] = din[in_w - tbl[i]];
    return r;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] s, input logic right);
    logic [27:0] r;
    r = x;
    for (int i = 0; i < int'(s); i++) r = right ? {r[0], r[27:1]} : {r[26:0], r[27]};
    return r;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    logic [63:0] p;
    x = permute({32'h0, r}, 32, e_t) [47:0] ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b = x[47 - 6*i -: 6];
      s[31 - 4*i -: 4] = 4'(sbox[i][{b[5], b[0], b[4:1]}]);
    end
    p = permute({32'h0, s}, 32, p_t);
    return p[31:0];
  endfunction

  // Reference DES with the textbook left-shift schedule, keys reversed for decrypt.
  function automatic logic [63:0] des_ref(input logic [63:0] d, input logic [63:0] k, input logic dec);
    logic [47:0] ks[16];
    logic [63:0] t64;
    logic [27:0] c, dd;
    logic [31:0] l, r, t;
    t64 = permute(k, 64, pc1_t);
    c   = t64[55:28];
    dd  = t64[27:0];
    for (int i = 0; i < 16; i++) begin
      c     = rot28(c,  (i == 0 || i == 1 || i == 8 || i == 15) ? 2'd1 : 2'd2, 1'b0);
      dd    = rot28(dd, (i == 0 || i == 1 || i == 8 || i == 15) ? 2'd1 : 2'd2, 1'b0);
      t64   = permute({8'h00, c, dd}, 56, pc2_t);
      ks[i] = t64[47:0];
    end
    t64 = permute(d, 64, ip_t);
    l   = t64[63:32];
    r   = t64[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ feistel(r, dec ? ks[15 - i] : ks[i]);
      l = t;
    end
    return permute({r, l}, 64, ipinv_t);
  endfunction

  // Behavioural round datapath driven by the sequencer's dp_* controls.
  logic [31:0] m_l, m_r, n_l, n_r;
  logic [27:0] m_c, m_d, n_c, n_d;
  logic [63:0] ipv, cdv, rkv;

  always_comb begin
    ipv = permute(dp_data, 64, ip_t);
    cdv = permute(dp_key, 64, pc1_t);
    n_l = m_l;
    n_r = m_r;
    n_c = m_c;
    n_d = m_d;
    rkv = '0;
    if (dp_load) begin
      n_l = ipv[63:32];
      n_r = ipv[31:0];
      n_c = cdv[55:28];
      n_d = cdv[27:0];
    end else if (dp_round_en) begin
      n_c = rot28(m_c, dp_key_shift, dp_key_dir);
      n_d = rot28(m_d, dp_key_shift, dp_key_dir);
      rkv = permute({8'h00, n_c, n_d}, 56, pc2_t);
      n_l = m_r;
      n_r = m_l ^ feistel(m_r, rkv[47:0]);
    end
  end

  always @(posedge ACLK) begin
    m_l <= n_l;
    m_r <= n_r;
    m_c <= n_c;
    m_d <= n_d;
  end

  assign dp_out = permute({m_r, m_l}, 64, ipinv_t);

  // Scoreboard: push on command handshake, pop on result handshake.
  logic [63:0] exp_q[$];

  always @(negedge ACLK) begin
    if (!ARESETN || abort) begin
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("sb_res_data", res_data, exp_q.pop_front());
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(des_ref(cmd_data, cmd_key, cmd_decrypt));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  int          t_acc, lat, load_cyc, final_cyc;
  logic [1:0]  shift_tr[$];
  logic [3:0]  idx_tr[$];
  int          enc_sh[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int          dec_sh[16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int          acc[4];
  logic [63:0] held, saved;
  logic [CNT_W-1:0] cnt_before;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] k, input logic dec, input logic keep_valid);
    int n;
    n = 0;
    cmd_data    = d;
    cmd_key     = k;
    cmd_decrypt = dec;
    cmd_valid   = 1'b1;
    while (!cmd_ready && n < 100) begin
      step();
      n++;
    end
    check("accept_timeout", 64'(cmd_ready), 64'd1);
    t_acc = cyc;
    step();
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    shift_tr.delete();
    idx_tr.delete();
    load_cyc  = -1;
    final_cyc = -1;
    while (!res_valid && n < 60) begin
      check("ctl_one_hot", 64'($countones({dp_load, dp_round_en, dp_final}) <= 1), 64'd1);
      if (dp_load) load_cyc = cyc;
      if (dp_round_en) begin
        shift_tr.push_back(dp_key_shift);
        idx_tr.push_back(dp_round_idx);
      end
      if (dp_final) final_cyc = cyc;
      step();
      n++;
    end
    check("result_timeout", 64'(res_valid), 64'd1);
    lat = cyc - t_acc;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    check({p, "_res_valid"}, 64'(res_valid), 64'd0);
    check({p, "_busy"}, 64'(busy), 64'd0);
    check({p, "_ctl"}, 64'({dp_load, dp_round_en, dp_final}), 64'd0);
    check({p, "_idx_shift_dir"}, 64'({dp_round_idx, dp_key_shift, dp_key_dir}), 64'd0);
    check({p, "_res_data"}, res_data, 64'd0);
    check({p, "_dp_data"}, dp_data, 64'd0);
    check({p, "_dp_key"}, dp_key, 64'd0);
    check({p, "_blk_count"}, 64'(blk_count), 64'd0);
  endtask

  initial begin
    ARESETN = 1'b0; abort = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_key = '0;
    cmd_decrypt = 1'b0; res_ready = 1'b0;
    repeat (3) step();
    check_reset_outputs("por");
    ARESETN = 1'b1;
    step();
    check("por_release_cmd_ready", 64'(cmd_ready), 64'd1);

    // Known encrypt vector with latency and schedule trace.
    res_ready = 1'b1;
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 1'b0);
    check("enc_dp_data", dp_data, 64'h0123456789ABCDEF);
    check("enc_dp_key", dp_key, 64'h133457799BBCDFF1);
    check("enc_dp_dir", 64'(dp_key_dir), 64'd0);
    wait_result();
    check("enc_latency", 64'(lat), 64'd19);
    check("enc_load_cycle", 64'(load_cyc - t_acc), 64'd1);
    check("enc_final_cycle", 64'(final_cyc - t_acc), 64'd18);
    check("enc_res_data", res_data, 64'h85E813540F0AB405);
    check("enc_round_count", 64'(shift_tr.size()), 64'd16);
    for (int i = 0; i < 16 && i < shift_tr.size(); i++) begin
      check($sformatf("enc_shift[%0d]", i), 64'(shift_tr[i]), 64'(enc_sh[i]));
      check($sformatf("enc_idx[%0d]", i), 64'(idx_tr[i]), 64'(i));
    end
    step();
    check("enc_blk_count", 64'(blk_count), 64'd1);
    check("enc_idle_ready", 64'(cmd_ready), 64'd1);

    // Known decrypt vector with reverse schedule trace.
    send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 1'b0);
    check("dec_dp_dir", 64'(dp_key_dir), 64'd1);
    wait_result();
    check("dec_res_data", res_data, 64'h0123456789ABCDEF);
    check("dec_round_count", 64'(shift_tr.size()), 64'd16);
    for (int i = 0; i < 16 && i < shift_tr.size(); i++)
      check($sformatf("dec_shift[%0d]", i), 64'(shift_tr[i]), 64'(dec_sh[i]));
    step();
    check("dec_blk_count", 64'(blk_count), 64'd2);

    // Backpressure: result held 50 cycles, stray command pulse ignored.
    res_ready = 1'b0;
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    wait_result();
    held = res_data;
    for (int i = 0; i < 50; i++) begin
      check("bp_res_data", res_data, held);
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      check("bp_res_valid", 64'(res_valid), 64'd1);
      cmd_valid = (i == 20);
      if (i == 20) cmd_data = ~held;
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step();
    check("bp_release_cmd_ready", 64'(cmd_ready), 64'd1);
    check("bp_release_res_valid", 64'(res_valid), 64'd0);
    check("bp_blk_count", 64'(blk_count), 64'd3);

    // Back-to-back with cmd_valid and res_ready held high.
    for (int b = 0; b < 4; b++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'(b), 1'b1);
      acc[b] = t_acc;
    end
    cmd_valid = 1'b0;
    wait_result();
    step();
    for (int b = 1; b < 4; b++)
      check($sformatf("b2b_spacing[%0d]", b), 64'(acc[b] - acc[b-1]), 64'd20);
    check("b2b_blk_count", 64'(blk_count), 64'd7);

    // Abort at round 7.
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    for (int n = 0; n < 30 && !(dp_round_en && dp_round_idx == 4'd7); n++) step();
    check("abort_reached_r7", 64'(dp_round_en && dp_round_idx == 4'd7), 64'd1);
    saved = dp_data;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort_dp_data", dp_data, saved);
    for (int i = 0; i < 25; i++) begin
      check("abort_no_res_valid", 64'(res_valid), 64'd0);
      step();
    end
    check("abort_blk_count", 64'(blk_count), 64'd7);

    // Abort in IDLE blocks a command.
    cmd_valid = 1'b1;
    cmd_data  = ~saved;
    abort     = 1'b1;
    step();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("abort_idle_busy", 64'(busy), 64'd0);
    check("abort_idle_dp_data", dp_data, saved);

    // Block after abort completes normally (scoreboard checks data).
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 1'b0);
    wait_result();
    check("post_abort_res_data", res_data, 64'h85E813540F0AB405);
    step();
    check("post_abort_blk_count", 64'(blk_count), 64'd8);

    // Abort in HOLD together with res_ready: no count, result kept.
    res_ready = 1'b0;
    send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 1'b0);
    wait_result();
    cnt_before = blk_count;
    res_ready  = 1'b1;
    abort      = 1'b1;
    step();
    abort = 1'b0;
    check("abort_hold_blk_count", 64'(blk_count), 64'(cnt_before));
    check("abort_hold_res_valid", 64'(res_valid), 64'd0);
    check("abort_hold_res_data", res_data, 64'h0123456789ABCDEF);

    // Reset during HOLD.
    res_ready = 1'b0;
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    wait_result();
    ARESETN = 1'b0;
    step();
    check_reset_outputs("hold_rst");
    ARESETN = 1'b1;
    step();
    check("hold_rst_release_cmd_ready", 64'(cmd_ready), 64'd1);

    // Counter wrap.
    res_ready = 1'b1;
    for (int b = 0; b < (1 << CNT_W); b++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      wait_result();
      step();
      if (b == (1 << CNT_W) - 2) check("wrap_max", 64'(blk_count), 64'((1 << CNT_W) - 1));
    end
    check("wrap_zero", 64'(blk_count), 64'd0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/des_round_sequencer.md
# des_round_sequencer

Control FSM for the iterative DES round datapath inside the des_encryption AXI4-Lite peripheral. It accepts one 64-bit block, key and mode from the register bank over a valid/ready handshake. It loads the datapath, steps it through 16 rounds with the correct key-schedule rotation for encrypt or decrypt, and captures the result. It then holds the result on a valid/ready output until the register bank reads it.

## Interface
Parameters:
- ROUNDS, 16, number of Feistel rounds sequenced. Fixed at 16 for DES; other values are unsupported.
- CNT_W, 16, width of the completed-block counter.

Ports:
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- abort  in  1  synchronous soft clear. Priority is below ARESETN and above everything else.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_data  in  64  plaintext or ciphertext block.
- cmd_key  in  64  DES key (parity bits passed through).
- cmd_decrypt  in  1  0 = encrypt, 1 = decrypt.
- res_valid  out  1  result held.
- res_ready  in  1  consumer takes result.
- res_data  out  64  registered result block.
- busy  out  1  high in any state other than IDLE.
- blk_count  out  CNT_W  number of completed result handshakes.
- dp_load  out  1  datapath applies IP to dp_data and PC-1 to dp_key.
- dp_data  out  64  registered copy of cmd_data.
- dp_key  out  64  registered copy of cmd_key.
- dp_round_en  out  1  datapath executes one round this cycle.
- dp_round_idx  out  4  current round, 0..15.
- dp_key_shift  out  2  C/D rotation amount for this round.
- dp_key_dir  out  1  0 = rotate left (encrypt), 1 = rotate right (decrypt).
- dp_final  out  1  datapath applies the final swap and IP⁻¹.
- dp_out  in  64  datapath output; valid in the dp_final cycle.

## Operation
- States and transitions:
  - IDLE → LOAD on cmd_valid && cmd_ready.
  - LOAD → ROUND after 1 cycle.
  - ROUND stays ROUND while round counter < 15; at counter 15 → FINAL.
  - FINAL → HOLD after 1 cycle.
  - HOLD → IDLE on res_ready.
- Command acceptance: on the handshake cycle, cmd_data, cmd_key and cmd_decrypt are registered into dp_data, dp_key and dp_key_dir. These stay stable until the next accept.
- LOAD: dp_load=1 for exactly 1 cycle. The round counter is cleared to 0.
- ROUND: dp_round_en=1 and dp_round_idx=counter; the counter increments each cycle.
- Key schedule, encrypt: dp_key_shift=1 at rounds 0, 1, 8, 15; otherwise 2.
- Key schedule, decrypt: dp_key_shift=0 at round 0; 1 at rounds 1, 8, 15; otherwise 2.
- dp_key_shift is 0 outside ROUND.
- FINAL: dp_final=1. dp_out is captured into res_data on that clock edge.
- HOLD: res_valid=1 and res_data is stable. cmd_ready stays 0 until the result handshake completes.
- blk_count increments by 1 on each res_valid && res_ready cycle and wraps from 2^CNT_W−1 to 0.
- abort in any state:
  - next state is IDLE and res_valid drops;
  - blk_count is not incremented, even if res_ready is high in the same cycle;
  - res_data, dp_data and dp_key keep their values.
- abort while in IDLE with cmd_valid high: the command is not accepted.
- Reset (ARESETN=0 at a clock edge), from any state:
  - state → IDLE;
  - cmd_ready=0 during reset, 1 on the first cycle after release;
  - res_valid, busy, dp_load, dp_round_en, dp_final = 0;
  - dp_round_idx, dp_key_shift, dp_key_dir = 0;
  - res_data, dp_data, dp_key, blk_count = 0.

## Timing
- Command handshake at cycle T. Then:
  - LOAD at T+1;
  - ROUND at T+2..T+17 (idx 0..15);
  - FINAL at T+18;
  - res_valid=1 from T+19.
- Latency: 19 cycles from command accept to res_valid.
- With res_ready held high:
  - result handshake at T+19, IDLE at T+20;
  - next accept possible at T+20;
  - throughput is 1 block per 20 cycles.
- All outputs are registered or decoded from state and counter only. There are no combinational paths from cmd_* or res_ready to outputs, except that HOLD exit depends on res_ready registered at the edge.
- dp_load, dp_round_en and dp_final are mutually exclusive; at most one is high per cycle.

## Test plan
- Encrypt vector: key 133457799BBCDFF1, data 0123456789ABCDEF, decrypt=0, paired with the team DES round datapath.
  - Required: res_data=85E813540F0AB405, res_valid first high exactly 19 cycles after accept, blk_count=1.
- Decrypt vector: same key, data 85E813540F0AB405, decrypt=1.
  - Required: res_data=0123456789ABCDEF.
  - Required: dp_key_shift trace 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with dp_key_dir=1.
- Backpressure: hold res_ready=0 for 50 cycles after res_valid.
  - Required: res_data stable, cmd_ready=0 throughout, and a cmd_valid pulse is ignored.
  - Required: the release cycle completes the handshake and cmd_ready=1 the next cycle.
- Back-to-back: 4 commands with cmd_valid and res_ready held high.
  - Required: accepts exactly 20 cycles apart and blk_count=4.
- Abort mid-round: assert abort for 1 cycle at round idx 7.
  - Required: next cycle IDLE, busy=0, res_valid never asserts, blk_count unchanged.
  - Required: a following command completes normally with the correct result.
- Reset and wrap:
  - drive ARESETN=0 for 1 cycle during HOLD; required: all outputs take their reset values and cmd_ready=1 one cycle after release;
  - preload blk_count by running 65536 blocks; required: blk_count wraps to 0.
